// File: rtl/fft_sample_feeder.sv
// fft_sample_feeder
// Buffers one frame of unsigned samples from upstream logic and replays it
// into the FFT core's start/number input port. A frame is launched only when
// the buffer is full and the core reports idle. After the last sample the
// block holds until the core is idle again before it accepts a new frame.
// Every output comes straight from a flop.

module fft_sample_feeder #(
   parameter int         FRAME_LEN = 16,
   parameter int         DATA_W    = 10,
   parameter logic [1:0] IDLE_CODE = 2'b00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              go,
   input  logic [1:0]        core_state,
   output logic              start,
   output logic [DATA_W-1:0] number,
   output logic              full,
   output logic              busy,
   output logic              done
);

   localparam int RD_W  = $clog2(FRAME_LEN);
   localparam int CNT_W = RD_W + 1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
   localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_ARM,
      S_STREAM,
      S_WAIT
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [RD_W-1:0]   rd;
   logic [RD_W-1:0]   rd_nxt;
   // Set after the first WAIT cycle so that WAIT always lasts at least two cycles.
   logic              wait_seen;
   logic              wait_seen_nxt;
   logic              wr_do;

   logic              start_nxt;
   logic [DATA_W-1:0] number_nxt;
   logic              full_nxt;
   logic              busy_nxt;
   logic              done_nxt;

   // Frame storage; contents are don't-care until written, so it has no reset.
   logic [DATA_W-1:0] sample_mem [FRAME_LEN];

   // Next-state logic: buffer fill, launch, stream sequencing and core handshake.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      rd_nxt        = rd;
      wait_seen_nxt = wait_seen;
      wr_do         = 1'b0;
      done_nxt      = 1'b0;

      unique case (state)
         S_LOAD: begin
            // A launch takes priority; a write in the same cycle cannot land
            // anyway because the buffer is already full.
            if (go && (cnt == CNT_FULL) && (core_state == IDLE_CODE)) begin
               state_nxt = S_ARM;
            end else if (wr_en && (cnt != CNT_FULL)) begin
               wr_do   = 1'b1;
               cnt_nxt = cnt + 1'b1;
            end
         end

         S_ARM: begin
            state_nxt = S_STREAM;
            rd_nxt    = '0;
         end

         S_STREAM: begin
            if (rd == RD_LAST) begin
               state_nxt     = S_WAIT;
               rd_nxt        = '0;
               wait_seen_nxt = 1'b0;
            end else begin
               rd_nxt = rd + 1'b1;
            end
         end

         S_WAIT: begin
            if (wait_seen && (core_state == IDLE_CODE)) begin
               state_nxt     = S_LOAD;
               cnt_nxt       = '0;
               done_nxt      = 1'b1;
               wait_seen_nxt = 1'b0;
            end else begin
               wait_seen_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = S_LOAD;
         end
      endcase
   end

   // Output values for the coming cycle, derived from where the FSM is heading
   // so that the registered outputs line up with the state they describe.
   always_comb begin
      start_nxt  = (state_nxt == S_ARM) ||
                   ((state_nxt == S_STREAM) && (rd_nxt == '0));
      number_nxt = (state_nxt == S_STREAM) ? sample_mem[rd_nxt] : '0;
      busy_nxt   = (state_nxt != S_LOAD);
      full_nxt   = (state_nxt == S_LOAD) && (cnt_nxt == CNT_FULL);
   end

   // Control state and registered outputs, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_LOAD;
         cnt       <= '0;
         rd        <= '0;
         wait_seen <= 1'b0;
         start     <= 1'b0;
         number    <= '0;
         full      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rd        <= rd_nxt;
         wait_seen <= wait_seen_nxt;
         start     <= start_nxt;
         number    <= number_nxt;
         full      <= full_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   // Sample capture; slot index is the current fill count.
   always_ff @(posedge clk) begin
      if (wr_do && !reset) begin
         sample_mem[cnt[RD_W-1:0]] <= wr_data;
      end
   end

endmodule

// File: tb/tb_fft_sample_feeder.sv
// Testbench for fft_sample_feeder: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.

module tb_fft_sample_feeder;

   localparam int         FL   = 16;
   localparam int         DW   = 10;
   localparam logic [1:0] IDLE = 2'b00;

   logic          clk;
   logic          reset;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          go;
   logic [1:0]    core_state;
   logic          start;
   logic [DW-1:0] number;
   logic          full;
   logic          busy;
   logic          done;

   int n_chk  = 0;
   int n_fail = 0;

   fft_sample_feeder #(
      .FRAME_LEN (FL),
      .DATA_W    (DW),
      .IDLE_CODE (IDLE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .go         (go),
      .core_state (core_state),
      .start      (start),
      .number     (number),
      .full       (full),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Frame = queue of accepted samples. A launch turns it into a schedule of
   // (start, number) words the core will see, ending with one idle word for
   // the transition into the hold phase. Once the schedule drains, the model
   // counts hold cycles until the core is idle (minimum two hold cycles).
   typedef struct packed {
      logic          s;
      logic [DW-1:0] n;
   } word_t;

   logic [DW-1:0] m_buf[$];
   word_t         m_sched[$];
   bit            m_busy = 1'b0;
   int            m_hold = 0;

   logic          e_start;
   logic [DW-1:0] e_num;
   logic          e_full;
   logic          e_busy;
   logic          e_done;

   function automatic void model_step(input logic r, input logic we, input logic [DW-1:0] wd,
                                      input logic g, input logic [1:0] cs);
      word_t w;
      e_done  = 1'b0;
      e_start = 1'b0;
      e_num   = '0;
      if (r) begin
         m_buf.delete();
         m_sched.delete();
         m_busy = 1'b0;
         m_hold = 0;
      end else if (!m_busy) begin
         if (g && (m_buf.size() == FL) && (cs == IDLE)) begin
            m_busy = 1'b1;
            m_hold = 0;
            w.s = 1'b1; w.n = '0;
            m_sched.push_back(w);
            for (int k = 0; k < FL; k++) begin
               w.s = (k == 0);
               w.n = m_buf[k];
               m_sched.push_back(w);
            end
            w.s = 1'b0; w.n = '0;
            m_sched.push_back(w);
         end else if (we && (m_buf.size() < FL)) begin
            m_buf.push_back(wd);
         end
      end else if (m_sched.size() == 0) begin
         if ((m_hold >= 1) && (cs == IDLE)) begin
            m_busy = 1'b0;
            m_buf.delete();
            e_done = 1'b1;
         end else begin
            m_hold++;
         end
      end
      if (m_sched.size() > 0) begin
         w       = m_sched.pop_front();
         e_start = w.s;
         e_num   = w.n;
      end
      e_busy = m_busy;
      e_full = !m_busy && (m_buf.size() == FL);
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // One clock: drive at the falling edge, step the model on the rising edge,
   // compare shortly after the rising edge.
   task automatic cycle(input logic r, input logic we, input logic [DW-1:0] wd,
                        input logic g, input logic [1:0] cs);
      @(negedge clk);
      reset      = r;
      wr_en      = we;
      wr_data    = wd;
      go         = g;
      core_state = cs;
      @(posedge clk);
      model_step(r, we, wd, g, cs);
      #1;
      chk("model_start",  {31'd0, start}, {31'd0, e_start});
      chk("model_number", {22'd0, number}, {22'd0, e_num});
      chk("model_full",   {31'd0, full},  {31'd0, e_full});
      chk("model_busy",   {31'd0, busy},  {31'd0, e_busy});
      chk("model_done",   {31'd0, done},  {31'd0, e_done});
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          r;
      logic          we;
      logic [DW-1:0] wd;
      logic          g;
      logic [1:0]    cs;
      logic          x_full;
      logic          x_busy;
      logic          x_start;
      logic [DW-1:0] x_num;
      logic          x_done;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic we, input logic [DW-1:0] wd,
                               input logic g, input logic [1:0] cs,
                               input logic xf, input logic xb, input logic xs,
                               input logic [DW-1:0] xn, input logic xd);
      vec_t v;
      v.r = r; v.we = we; v.wd = wd; v.g = g; v.cs = cs;
      v.x_full = xf; v.x_busy = xb; v.x_start = xs; v.x_num = xn; v.x_done = xd;
      vecs.push_back(v);
   endfunction

   int samp [FL] = '{10, 18, 19, 12, 3, 0, 6, 15, 20, 16, 7, 0, 2, 11, 19, 19};

   initial begin
      int lat;
      vec_t v;

      reset      = 1'b1;
      wr_en      = 1'b0;
      wr_data    = '0;
      go         = 1'b0;
      core_state = IDLE;

      // Reset, fill, ignored 17th write, refused go (core busy), accepted go.
      add(1, 0, 10'd0, 0, 2'b00,   0, 0, 0, 10'd0, 0);
      for (int i = 0; i < FL; i++)
         add(0, 1, DW'(samp[i]), 0, 2'b00,   (i == FL - 1), 0, 0, 10'd0, 0);
      add(0, 1, 10'h3ff, 0, 2'b00,  1, 0, 0, 10'd0, 0);
      add(0, 0, 10'd0, 1, 2'b01,    1, 0, 0, 10'd0, 0);
      add(0, 0, 10'd0, 1, 2'b00,    0, 1, 1, 10'd0, 0);
      // Streaming with writes and go pulses that must be ignored.
      for (int i = 0; i < FL; i++)
         add(0, 1, 10'h155, (i % 2 == 1), 2'b10,   0, 1, (i == 0), DW'(samp[i]), 0);
      // Hold phase with the core busy for 21 cycles, then idle.
      for (int i = 0; i < 21; i++)
         add(0, 0, 10'd0, 0, 2'b10,  0, 1, 0, 10'd0, 0);
      add(0, 0, 10'd0, 0, 2'b00,    0, 0, 0, 10'd0, 1);
      add(0, 0, 10'd0, 0, 2'b00,    0, 0, 0, 10'd0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         cycle(v.r, v.we, v.wd, v.g, v.cs);
         chk($sformatf("vec%0d_start", i),  {31'd0, start}, {31'd0, v.x_start});
         chk($sformatf("vec%0d_number", i), {22'd0, number}, {22'd0, v.x_num});
         chk($sformatf("vec%0d_full", i),   {31'd0, full},  {31'd0, v.x_full});
         chk($sformatf("vec%0d_busy", i),   {31'd0, busy},  {31'd0, v.x_busy});
         chk($sformatf("vec%0d_done", i),   {31'd0, done},  {31'd0, v.x_done});
      end

      // go after only 15 writes is refused; the 16th write then enables launch.
      for (int i = 0; i < FL - 1; i++)
         cycle(0, 1, DW'($urandom_range(0, 1023)), 0, IDLE);
      cycle(0, 0, 10'd0, 1, IDLE);
      chk("short_go_start", {31'd0, start}, 32'd0);
      chk("short_go_busy",  {31'd0, busy},  32'd0);
      chk("short_go_full",  {31'd0, full},  32'd0);
      cycle(0, 1, DW'($urandom_range(0, 1023)), 0, IDLE);
      chk("refill_full", {31'd0, full}, 32'd1);
      cycle(0, 0, 10'd0, 1, IDLE);
      chk("launch_start", {31'd0, start}, 32'd1);
      chk("launch_busy",  {31'd0, busy},  32'd1);
      // With the core idle throughout, done lands 19 edges after the go edge.
      lat = -1;
      for (int j = 1; j <= 40; j++) begin
         cycle(0, 0, 10'd0, 0, IDLE);
         if (done === 1'b1) begin
            lat = j;
            break;
         end
      end
      chk("done_latency", lat, 32'd19);
      // Next go right after done with an empty buffer is refused.
      cycle(0, 0, 10'd0, 1, IDLE);
      chk("post_done_go_busy", {31'd0, busy}, 32'd0);

      // Reset during the 5th streaming cycle abandons the frame.
      for (int i = 0; i < FL; i++)
         cycle(0, 1, DW'($urandom_range(0, 1023)), 0, IDLE);
      cycle(0, 0, 10'd0, 1, IDLE);
      for (int i = 0; i < 5; i++)
         cycle(0, 0, 10'd0, 0, IDLE);
      cycle(1, 0, 10'd0, 0, IDLE);
      chk("rst_mid_start",  {31'd0, start}, 32'd0);
      chk("rst_mid_number", {22'd0, number}, 32'd0);
      chk("rst_mid_busy",   {31'd0, busy},  32'd0);
      chk("rst_mid_full",   {31'd0, full},  32'd0);
      for (int i = 0; i < 12; i++) begin
         cycle(0, 0, 10'd0, 0, IDLE);
         chk("rst_mid_no_done", {31'd0, done}, 32'd0);
      end
      // Count restarted at zero: 15 writes leave the buffer not full.
      for (int i = 0; i < FL - 1; i++)
         cycle(0, 1, DW'($urandom_range(0, 1023)), 0, IDLE);
      chk("rst_cnt_cleared", {31'd0, full}, 32'd0);
      cycle(0, 1, DW'($urandom_range(0, 1023)), 0, IDLE);
      chk("rst_refill_full", {31'd0, full}, 32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic       r, we, g;
         logic [1:0] cs;
         r  = ($urandom_range(0, 149) == 0);
         we = 1'($urandom_range(0, 1));
         g  = ($urandom_range(0, 3) == 0);
         cs = ($urandom_range(0, 1) == 1) ? IDLE : 2'($urandom_range(1, 3));
         cycle(r, we, DW'($urandom_range(0, 1023)), g, cs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
